// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, FSM state type and rotate helper for sha1_block_core.
package sha1_pkg;

    localparam logic [31:0] H0_INIT = 32'h67452301;
    localparam logic [31:0] H1_INIT = 32'hEFCDAB89;
    localparam logic [31:0] H2_INIT = 32'h98BADCFE;
    localparam logic [31:0] H3_INIT = 32'h10325476;
    localparam logic [31:0] H4_INIT = 32'hC3D2E1F0;
    localparam logic [159:0] H_INIT = {H0_INIT, H1_INIT, H2_INIT, H3_INIT, H4_INIT};

    localparam logic [31:0] K0 = 32'h5A827999;
    localparam logic [31:0] K1 = 32'h6ED9EBA1;
    localparam logic [31:0] K2 = 32'h8F1BBCDC;
    localparam logic [31:0] K3 = 32'hCA62C1D6;

    localparam logic [6:0] LAST_ROUND = 7'd79;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } state_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/sha1_block_core_if.sv
// Request/result bundle between the hashing datapath and sha1_block_core.
interface sha1_block_core_if;
    logic         start;
    logic [159:0] context_in;
    logic [511:0] block;
    logic         done;
    logic [159:0] context_out;

    modport master (
        output start, context_in, block,
        input  done, context_out
    );

    modport slave (
        input  start, context_in, block,
        output done, context_out
    );
endinterface

// File: rtl/sha1_round.sv
// One combinational SHA-1 round: picks f/k from the round index and rotates a..e.
module sha1_round
    import sha1_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] e,
    input  logic [31:0] w,
    input  logic [6:0]  t,
    output logic [31:0] a_next,
    output logic [31:0] b_next,
    output logic [31:0] c_next,
    output logic [31:0] d_next,
    output logic [31:0] e_next,
    output logic [31:0] f,
    output logic [31:0] k
);

    always_comb begin
        f = '0;
        k = '0;
        if (t < 7'd20) begin
            f = (b & c) | (~b & d);
            k = K0;
        end else if (t < 7'd40) begin
            f = b ^ c ^ d;
            k = K1;
        end else if (t < 7'd60) begin
            f = (b & c) | (b & d) | (c & d);
            k = K2;
        end else begin
            f = b ^ c ^ d;
            k = K3;
        end
    end

    assign a_next = rotl(a, 5) + f + e + k + w;
    assign b_next = a;
    assign c_next = rotl(b, 30);
    assign d_next = c;
    assign e_next = d;

endmodule

// File: rtl/sha1_block_core.sv
// Iterative SHA-1 compression: 80 rounds at one per clock, then the Davies-Meyer add.
// Defining SHA1_ROUND_PORT_EN adds a round_idx output showing the current round.
module sha1_block_core
    import sha1_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
`ifdef SHA1_ROUND_PORT_EN
    output logic [6:0]       round_idx,
`endif
    sha1_block_core_if.slave bus
);

    state_t       state;
    state_t       next_state;
    logic         accept;
    logic [31:0]  a, b, c, d, e, f, k, w;
    logic [31:0]  a_next, b_next, c_next, d_next, e_next;
    logic [31:0]  w_new;
    logic [6:0]   t;
    logic [159:0] ctx;
    logic [31:0]  sched [16];
    logic         done_r;
    logic [159:0] result;

    assign w               = sched[0];
    assign w_new           = rotl(sched[13] ^ sched[8] ^ sched[2] ^ sched[0], 1);
    assign bus.done        = done_r;
    assign bus.context_out = result;

`ifdef SHA1_ROUND_PORT_EN
    assign round_idx = (state == ROUND) ? t : 7'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start is only honoured when no compression is in flight
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = ROUND;
                end
            end
            ROUND:   if (t == LAST_ROUND) next_state = FINAL;
            FINAL:   next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    sha1_round u_round (
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .e      (e),
        .w      (w),
        .t      (t),
        .a_next (a_next),
        .b_next (b_next),
        .c_next (c_next),
        .d_next (d_next),
        .e_next (e_next),
        .f      (f),
        .k      (k)
    );

    // The schedule register holds w_t..w_t+15; each round drops the head and appends w_t+16
    always_ff @(posedge clk) begin
        if (rst) begin
            a      <= '0;
            b      <= '0;
            c      <= '0;
            d      <= '0;
            e      <= '0;
            t      <= '0;
            ctx    <= '0;
            done_r <= 1'b0;
            result <= '0;
            for (int i = 0; i < 16; i++) sched[i] <= '0;
        end else if (accept) begin
            ctx    <= bus.context_in;
            a      <= bus.context_in[159:128];
            b      <= bus.context_in[127:96];
            c      <= bus.context_in[95:64];
            d      <= bus.context_in[63:32];
            e      <= bus.context_in[31:0];
            t      <= '0;
            done_r <= 1'b0;
            for (int i = 0; i < 16; i++) sched[i] <= bus.block[511 - 32*i -: 32];
        end else if (state == ROUND) begin
            a <= a_next;
            b <= b_next;
            c <= c_next;
            d <= d_next;
            e <= e_next;
            t <= t + 7'd1;
            for (int i = 0; i < 15; i++) sched[i] <= sched[i+1];
            sched[15] <= w_new;
        end else if (state == FINAL) begin
            result <= {ctx[159:128] + a, ctx[127:96] + b, ctx[95:64] + c,
                       ctx[63:32] + d, ctx[31:0] + e};
            done_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sha1_block_core.sv
// Directed bench for sha1_block_core using published SHA-1 digests as expected values.
module tb_sha1_block_core;
    import sha1_pkg::*;

    localparam logic [159:0] HASH_EMPTY = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
    localparam logic [159:0] HASH_ABC   = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] HASH_TWO   = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;
    localparam logic [159:0] H_START    = 160'h67452301efcdab8998badcfe10325476c3d2e1f0;

    localparam logic [511:0] BLK_EMPTY = {8'h80, 504'h0};
    localparam logic [511:0] BLK_ABC   = {"abc", 8'h80, 416'h0, 64'd24};
    localparam logic [511:0] BLK_TWO_A =
        {"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 8'h80, 56'h0};
    localparam logic [511:0] BLK_TWO_B = {448'h0, 64'd448};

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   lat;

    always #5 clk = ~clk;

    sha1_block_core_if bus ();

    sha1_block_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Raises start for 'pulse' edges (or until done if hold), returns edges from accept to done
    task automatic applyStimulus(input logic [159:0] ctx, input logic [511:0] blk,
                                 input int pulse, input bit hold, input bit corrupt,
                                 output int latency);
        latency = -1;
        @(negedge clk);
        bus.context_in = ctx;
        bus.block      = blk;
        bus.start      = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (corrupt && n == 0) begin
                bus.context_in = ~ctx;
                bus.block      = ~blk;
            end
            if (!hold && n + 1 >= pulse) bus.start = 1'b0;
            if (bus.done) begin
                latency = n;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.context_in = '0;
        bus.block      = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_done", 160'(bus.done), 160'(0));
        checkOutput("rst_ctx", bus.context_out, 160'h0);
        checkOutput("rst_a", 160'(dut.a), 160'h0);
        checkOutput("rst_t", 160'(dut.t), 160'h0);
        checkOutput("rst_state", 160'(dut.state), 160'(IDLE));
        rst = 1'b0;

        applyStimulus(H_START, BLK_EMPTY, 3, 1'b0, 1'b0, lat);
        checkOutput("empty_lat", 160'(lat), 160'(81));
        checkOutput("empty_hash", bus.context_out, HASH_EMPTY);

        applyStimulus(H_START, BLK_ABC, 1, 1'b0, 1'b0, lat);
        checkOutput("abc_lat", 160'(lat), 160'(81));
        checkOutput("abc_hash", bus.context_out, HASH_ABC);

        applyStimulus(H_START, BLK_EMPTY, 1, 1'b1, 1'b0, lat);
        checkOutput("hold_lat", 160'(lat), 160'(81));
        checkOutput("hold_hash", bus.context_out, HASH_EMPTY);
        bus.context_in = '0;
        bus.block      = '0;
        repeat (5) @(negedge clk);
        checkOutput("keep_done", 160'(bus.done), 160'(1));
        checkOutput("keep_hash", bus.context_out, HASH_EMPTY);
        checkOutput("keep_state", 160'(dut.state), 160'(DONE));

        applyStimulus(H_START, BLK_TWO_A, 1, 1'b0, 1'b0, lat);
        checkOutput("two_a_lat", 160'(lat), 160'(81));
        applyStimulus(bus.context_out, BLK_TWO_B, 1, 1'b0, 1'b0, lat);
        checkOutput("two_b_lat", 160'(lat), 160'(81));
        checkOutput("two_hash", bus.context_out, HASH_TWO);

        @(negedge clk);
        bus.context_in = H_START;
        bus.block      = BLK_EMPTY;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("mid_t", 160'(dut.t), 160'(40));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_done", 160'(bus.done), 160'(0));
        checkOutput("abort_ctx", bus.context_out, 160'h0);
        checkOutput("abort_state", 160'(dut.state), 160'(IDLE));
        checkOutput("abort_a", 160'(dut.a), 160'h0);
        rst = 1'b0;

        applyStimulus(H_START, BLK_EMPTY, 1, 1'b0, 1'b0, lat);
        checkOutput("post_rst_lat", 160'(lat), 160'(81));
        checkOutput("post_rst_hash", bus.context_out, HASH_EMPTY);

        applyStimulus(H_START, BLK_EMPTY, 1, 1'b0, 1'b1, lat);
        checkOutput("change_lat", 160'(lat), 160'(81));
        checkOutput("change_hash", bus.context_out, HASH_EMPTY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
